// File: rtl/charrec_pio_pkg.sv
// rtl/charrec_pio_pkg.sv - register offsets, edge polarity constants and edge select helper
package charrec_pio_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_EDGEPOL = 2'd1;
  localparam logic [1:0] REG_IRQMASK = 2'd2;
  localparam logic [1:0] REG_EDGECAP = 2'd3;

  localparam logic POL_FALL = 1'b0;
  localparam logic POL_RISE = 1'b1;

  // True when the filtered line moved in the direction selected by pol.
  function automatic logic edge_hit(input logic pol, input logic cur, input logic prev);
    return (pol == POL_RISE) ? (cur & ~prev) : (~cur & prev);
  endfunction

endpackage

// File: rtl/charrec_pio_filter.sv
// rtl/charrec_pio_filter.sv - per-line 2-flop synchroniser and debounce filter (PIO_DEBOUNCE_EN)
module charrec_pio_filter #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic sync_a;
  logic sync_b;

  // Two-stage synchroniser for the asynchronous recogniser pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= din;
      sync_b <= sync_a;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count consecutive cycles the synchronised level disagrees with the output; adopt it once stable long enough.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (sync_b == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      dout <= sync_b;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  localparam int UNUSED_DEBOUNCE = DEBOUNCE_CYCLES;

  // Without debounce the filtered level simply follows the synchroniser one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout <= 1'b0;
    end else begin
      dout <= sync_b;
    end
  end
`endif

endmodule

// File: rtl/charrec_pio_irq_ctrl.sv
// rtl/charrec_pio_irq_ctrl.sv - Avalon-MM edge-capture PIO with maskable irq; debounce enabled by PIO_DEBOUNCE_EN
module charrec_pio_irq_ctrl
  import charrec_pio_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] edge_pol;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_ok;

  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    charrec_pio_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .dout   (filt[i])
    );
  end

  // Upper writedata bits beyond WIDTH are intentionally ignored.
  assign unused_ok = &{1'b0, writedata};

  assign wr_en   = chipselect & ~write_n;
  assign cap_clr = (wr_en && (address == REG_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  // Per-bit edge detection against the previous filtered level, honouring the selected polarity.
  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit[i] = edge_hit(edge_pol[i], filt[i], filt_q[i]);
    end
  end

  // Register read mux; unused upper bits stay 0.
  always_comb begin
    rd_mux = '0;
    case (address)
      REG_DATA:    rd_mux[WIDTH-1:0] = filt;
      REG_EDGEPOL: rd_mux[WIDTH-1:0] = edge_pol;
      REG_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      REG_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
      default:     rd_mux = '0;
    endcase
  end

  // Software-writable configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_pol <= '0;
      irq_mask <= '0;
    end else if (wr_en) begin
      if (address == REG_EDGEPOL) edge_pol <= writedata[WIDTH-1:0];
      if (address == REG_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Sticky edge capture: W1C clear, but a same-cycle edge keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q   <= '0;
      edge_cap <= '0;
    end else begin
      filt_q   <= filt;
      edge_cap <= (edge_cap & ~cap_clr) | hit;
    end
  end

  // Registered interrupt and zero-wait-state read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      irq      <= |(edge_cap & irq_mask);
      readdata <= chipselect ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_charrec_pio_irq_ctrl.sv
// tb/tb_charrec_pio_irq_ctrl.sv - randomized and directed bench for charrec_pio_irq_ctrl (PIO_DEBOUNCE_EN aware)
module tb_charrec_pio_irq_ctrl;

  localparam int WIDTH = 4;
  localparam int DEB   = 16;
`ifdef PIO_DEBOUNCE_EN
  localparam int D = DEB;
`else
  localparam int D = 1;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             chipselect;
  logic [1:0]       address;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, all values as seen just after the most recent clock edge.
  logic [WIDTH-1:0] m_pol, m_mask, m_cap, m_filt, m_filt_prev, m_pin_d1;
  logic [WIDTH-1:0] m_sync_q[$];
  logic             m_irq;
  logic [31:0]      m_rd;

  charrec_pio_irq_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .chipselect(chipselect),
    .address   (address),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pol = '0; m_mask = '0; m_cap = '0; m_filt = '0; m_filt_prev = '0; m_pin_d1 = '0;
    m_irq = 1'b0; m_rd = '0;
    m_sync_q.delete();
    for (int i = 0; i < D; i++) m_sync_q.push_back('0);
  endtask

  // One clock edge of the behavioural model, using the bus/pin values present at the edge.
  task automatic model_edge();
    logic [WIDTH-1:0] flip, rise, fall, hits, clr, sync_now;
    logic [31:0]      regv;
    logic             wr;
    // A line flips once the synchronised copy has disagreed with it for the last D edges.
    flip = '1;
    foreach (m_sync_q[j]) flip &= (m_sync_q[j] ^ m_filt);
    rise = m_filt & ~m_filt_prev;
    fall = ~m_filt & m_filt_prev;
    hits = (m_pol & rise) | (~m_pol & fall);
    wr   = chipselect && !write_n;
    clr  = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    regv = '0;
    case (address)
      2'd0: regv[WIDTH-1:0] = m_filt;
      2'd1: regv[WIDTH-1:0] = m_pol;
      2'd2: regv[WIDTH-1:0] = m_mask;
      default: regv[WIDTH-1:0] = m_cap;
    endcase
    m_rd  = chipselect ? regv : 32'd0;
    m_irq = |(m_cap & m_mask);
    m_cap = (m_cap & ~clr) | hits;
    if (wr && address == 2'd1) m_pol  = writedata[WIDTH-1:0];
    if (wr && address == 2'd2) m_mask = writedata[WIDTH-1:0];
    m_filt_prev = m_filt;
    m_filt      = m_filt ^ flip;
    sync_now    = m_pin_d1;
    m_pin_d1    = in_port;
    m_sync_q.push_back(sync_now);
    void'(m_sync_q.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("readdata", readdata, m_rd);
    check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; address = a; writedata = d; write_n = 1'b0;
    step();
    write_n = 1'b1;
  endtask

  task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    chipselect = 1'b1; address = a; write_n = 1'b1;
    step();
    check_eq(tag, readdata, exp);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_readdata", readdata, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int lat;
    reset_n = 1'b0; chipselect = 1'b0; address = 2'd0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("reset_readdata", readdata, 32'd0);
    check_eq("reset_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    bus_read("data_rst", 2'd0, 32'd0);
    bus_read("edgepol_rst", 2'd1, 32'd0);
    bus_read("irqmask_rst", 2'd2, 32'd0);
    bus_read("edgecap_rst", 2'd3, 32'd0);

    // Bits above WIDTH read 0; writes to DATA are ignored.
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read("edgepol_width", 2'd1, 32'h0000_000F);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read("data_ro", 2'd0, 32'd0);
    bus_write(2'd1, 32'h1);

    // Short glitch: rejected only when debounce is longer than the pulse.
    in_port = 4'h1;
    steps(10);
    in_port = 4'h0;
    steps(30);
    bus_read("glitch_cap", 2'd3, (D > 10) ? 32'd0 : 32'd1);
    bus_write(2'd3, 32'hF);
    steps(2);

    // Pin-to-EDGECAP latency, seen on readdata one edge later.
    address = 2'd3;
    in_port = 4'h1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (readdata[0] !== 1'b1 && lat < 100);
    check_eq("cap_latency", lat, D + 4);
    bus_read("data_high", 2'd0, 32'd1);

    // irq asserts with mask, drops after W1C and after unmask.
    bus_write(2'd2, 32'h1);
    step();
    check_eq("irq_on", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'h1);
    step();
    check_eq("irq_clr1", {31'd0, irq}, 32'd0);
    step();
    check_eq("irq_clr2", {31'd0, irq}, 32'd0);
    bus_write(2'd1, 32'h0);
    in_port = 4'h0;
    steps(D + 6);
    check_eq("irq_fall", {31'd0, irq}, 32'd1);
    bus_write(2'd2, 32'h0);
    step();
    check_eq("irq_unmask", {31'd0, irq}, 32'd0);

    // Collision: W1C on the very edge that sets the bit.
    bus_write(2'd3, 32'hF);
    bus_write(2'd1, 32'h1);
    steps(2);
    in_port = 4'h1;
    steps(D + 2);
    bus_write(2'd3, 32'h1);
    bus_read("collision", 2'd3, 32'd1);

    // Falling polarity: only the 1->0 transition is captured.
    in_port = 4'h0;
    steps(32);
    bus_write(2'd3, 32'hF);
    bus_write(2'd1, 32'h0);
    in_port = 4'h1;
    steps(32);
    bus_read("pol_rise_ignored", 2'd3, 32'd0);
    in_port = 4'h0;
    steps(32);
    bus_read("pol_fall_taken", 2'd3, 32'd1);

    // Asynchronous reset mid-operation.
    bus_write(2'd2, 32'hF);
    step();
    check_eq("irq_before_rst", {31'd0, irq}, 32'd1);
    in_port = 4'h5;
    do_reset();
    bus_read("edgepol_after_rst", 2'd1, 32'd0);
    bus_read("irqmask_after_rst", 2'd2, 32'd0);
    bus_read("edgecap_after_rst", 2'd3, 32'd0);
    in_port = 4'h0;

    // Randomized traffic against the model.
    for (int c = 0; c < 1600; c++) begin
      if ($urandom_range(0, 11) == 0) in_port = WIDTH'($urandom);
      chipselect = ($urandom_range(0, 7) != 0);
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom);
      writedata  = $urandom;
      if (c == 800) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
